// File: rtl/rggen_register_access_arbiter_if.sv
// Bundle of the requester-side and register-block-side signals of the
// register access arbiter. The arbiter sits on the slave modport; the
// requesters and the register block together sit on the master modport.
interface rggen_register_access_arbiter_if #(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  // requester side
  logic [REQUESTERS-1:0]               i_req_valid;
  logic [2*REQUESTERS-1:0]             i_req_access;
  logic [ADDRESS_WIDTH*REQUESTERS-1:0] i_req_address;
  logic [BUS_WIDTH*REQUESTERS-1:0]     i_req_write_data;
  logic [BUS_WIDTH/8*REQUESTERS-1:0]   i_req_strobe;
  logic [REQUESTERS-1:0]               o_req_ready;
  logic [1:0]                          o_req_status;
  logic [BUS_WIDTH-1:0]                o_req_read_data;
  // register block side
  logic                                o_valid;
  logic [1:0]                          o_access;
  logic [ADDRESS_WIDTH-1:0]            o_address;
  logic [BUS_WIDTH-1:0]                o_write_data;
  logic [BUS_WIDTH/8-1:0]              o_strobe;
  logic                                i_ready;
  logic [1:0]                          i_status;
  logic [BUS_WIDTH-1:0]                i_read_data;

  modport slave (
    input  i_req_valid, i_req_access, i_req_address, i_req_write_data, i_req_strobe,
    output o_req_ready, o_req_status, o_req_read_data,
    output o_valid, o_access, o_address, o_write_data, o_strobe,
    input  i_ready, i_status, i_read_data
  );

  modport master (
    output i_req_valid, i_req_access, i_req_address, i_req_write_data, i_req_strobe,
    input  o_req_ready, o_req_status, o_req_read_data,
    input  o_valid, o_access, o_address, o_write_data, o_strobe,
    output i_ready, i_status, i_read_data
  );
endinterface

// File: rtl/rggen_register_access_arbiter.sv
// Round-robin arbiter sharing one register-block host port between
// REQUESTERS requesters. The granted request is latched, presented to the
// register block until it answers (or the watchdog expires), and the
// response is returned to the winner with a one-cycle ready pulse.
module rggen_register_access_arbiter #(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int TIMEOUT       = 0
)(
  input logic                            i_clk,
  input logic                            i_rst_n,
  rggen_register_access_arbiter_if.slave bus
);
  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int IDX_W  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } state_e;

  state_e                   state;
  logic [IDX_W-1:0]         ptr;
  logic [IDX_W-1:0]         grant;
  logic [CNT_W-1:0]         count;

  logic                     arb_found;
  logic [IDX_W-1:0]         arb_idx;
  logic [IDX_W-1:0]         ptr_next;
  logic [REQUESTERS-1:0]    valid_rot;
  logic [IDX_W:0]           idx_sum;
  logic [1:0]               sel_access;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [BUS_WIDTH-1:0]     sel_write_data;
  logic [STRB_W-1:0]        sel_strobe;
  logic [REQUESTERS-1:0]    grant_onehot;
  logic                     timeout_hit;

  // Round-robin pick: rotate the valids so the pointer lands on bit 0,
  // take the first set bit, then map the offset back to a requester index.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    idx_sum   = '0;
    valid_rot = REQUESTERS'({bus.i_req_valid, bus.i_req_valid} >> ptr);
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      if (!arb_found && valid_rot[k]) begin
        arb_found = 1'b1;
        idx_sum   = {1'b0, ptr} + (IDX_W+1)'(k);
        if (idx_sum >= (IDX_W+1)'(REQUESTERS)) begin
          idx_sum = idx_sum - (IDX_W+1)'(REQUESTERS);
        end
        arb_idx = idx_sum[IDX_W-1:0];
      end
    end
  end

  // Payload mux of the requester selected by the arbiter.
  always_comb begin
    sel_access     = '0;
    sel_address    = '0;
    sel_write_data = '0;
    sel_strobe     = '0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      if (IDX_W'(k) == arb_idx) begin
        sel_access     = bus.i_req_access[2*k +: 2];
        sel_address    = bus.i_req_address[ADDRESS_WIDTH*k +: ADDRESS_WIDTH];
        sel_write_data = bus.i_req_write_data[BUS_WIDTH*k +: BUS_WIDTH];
        sel_strobe     = bus.i_req_strobe[STRB_W*k +: STRB_W];
      end
    end
  end

  // Pointer advance, ready pulse vector and watchdog expiry.
  always_comb begin
    ptr_next     = (arb_idx == IDX_W'(REQUESTERS - 1)) ? '0 : arb_idx + 1'b1;
    grant_onehot = REQUESTERS'(1) << grant;
    timeout_hit  = (TIMEOUT > 0) && (count == CNT_W'(TIMEOUT - 1));
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= IDLE;
      ptr                 <= '0;
      grant               <= '0;
      count               <= '0;
      bus.o_req_ready     <= '0;
      bus.o_req_status    <= '0;
      bus.o_req_read_data <= '0;
      bus.o_valid         <= 1'b0;
      bus.o_access        <= '0;
      bus.o_address       <= '0;
      bus.o_write_data    <= '0;
      bus.o_strobe        <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.o_req_ready <= '0;
          if (arb_found) begin
            grant            <= arb_idx;
            ptr              <= ptr_next;
            count            <= '0;
            bus.o_access     <= sel_access;
            bus.o_address    <= sel_address;
            bus.o_write_data <= sel_write_data;
            bus.o_strobe     <= sel_strobe;
            bus.o_valid      <= 1'b1;
            state            <= BUSY;
          end
        end
        BUSY: begin
          count <= count + 1'b1;
          // a real answer takes priority over a coincident watchdog expiry
          if (bus.i_ready) begin
            bus.o_req_status    <= bus.i_status;
            bus.o_req_read_data <= bus.i_read_data;
            bus.o_valid         <= 1'b0;
            bus.o_req_ready     <= grant_onehot;
            state               <= RESPOND;
          end else if (timeout_hit) begin
            bus.o_req_status    <= 2'b10;
            bus.o_req_read_data <= '0;
            bus.o_valid         <= 1'b0;
            bus.o_req_ready     <= grant_onehot;
            state               <= RESPOND;
          end
        end
        RESPOND: begin
          bus.o_req_ready <= '0;
          state           <= IDLE;
        end
        default: begin
          bus.o_req_ready <= '0;
          bus.o_valid     <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// Bench for the register access arbiter: two instances (watchdog off and
// watchdog = 4 cycles), a transaction-level reference model per instance
// compared on every falling edge, and directed scenarios with literal
// expectations.
module tb_rggen_register_access_arbiter;
  localparam int N  = 2;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // stimulus, one entry per instance
  logic [N-1:0]    req_valid [2];
  logic [2*N-1:0]  req_access[2];
  logic [AW*N-1:0] req_addr  [2];
  logic [BW*N-1:0] req_wdata [2];
  logic [SW*N-1:0] req_strb  [2];
  logic            rdy       [2];
  logic [1:0]      rstat     [2];
  logic [BW-1:0]   rrd       [2];

  // observed outputs
  logic [N-1:0]    q_ready [2];
  logic [1:0]      q_status[2];
  logic [BW-1:0]   q_rdata [2];
  logic            q_valid [2];
  logic [1:0]      q_access[2];
  logic [AW-1:0]   q_addr  [2];
  logic [BW-1:0]   q_wdata [2];
  logic [SW-1:0]   q_strb  [2];

  task automatic chk(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s actual=%0h expected=%0h (t=%0t)", d, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int TO = (g == 1) ? 4 : 0;

    rggen_register_access_arbiter_if #(
      .REQUESTERS(N), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)
    ) bus ();

    assign bus.i_req_valid      = req_valid[g];
    assign bus.i_req_access     = req_access[g];
    assign bus.i_req_address    = req_addr[g];
    assign bus.i_req_write_data = req_wdata[g];
    assign bus.i_req_strobe     = req_strb[g];
    assign bus.i_ready          = rdy[g];
    assign bus.i_status         = rstat[g];
    assign bus.i_read_data      = rrd[g];
    assign q_ready[g]  = bus.o_req_ready;
    assign q_status[g] = bus.o_req_status;
    assign q_rdata[g]  = bus.o_req_read_data;
    assign q_valid[g]  = bus.o_valid;
    assign q_access[g] = bus.o_access;
    assign q_addr[g]   = bus.o_address;
    assign q_wdata[g]  = bus.o_write_data;
    assign q_strb[g]   = bus.o_strobe;

    rggen_register_access_arbiter #(
      .REQUESTERS(N), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT(TO)
    ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
    );

    // Reference model: an open transaction (owner + payload) waits for
    // the register block; its outcome is published for one cycle, one
    // idle cycle follows, then the next owner is chosen round-robin.
    int            m_ptr, m_owner, m_waited;
    bit            m_busy, m_pulse;
    logic [1:0]    m_acc, m_stat;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wd, m_rd;
    logic [SW-1:0] m_st;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_ptr <= 0; m_owner <= 0; m_waited <= 0; m_busy <= 0; m_pulse <= 0;
        m_acc <= '0; m_stat <= '0; m_addr <= '0; m_wd <= '0; m_rd <= '0; m_st <= '0;
      end else if (m_busy) begin
        m_waited <= m_waited + 1;
        if (rdy[g]) begin
          m_stat <= rstat[g]; m_rd <= rrd[g]; m_busy <= 0; m_pulse <= 1;
        end else if (TO > 0 && m_waited + 1 == TO) begin
          m_stat <= 2'b10; m_rd <= '0; m_busy <= 0; m_pulse <= 1;
        end
      end else if (m_pulse) begin
        m_pulse <= 0;
      end else begin : arb
        automatic int pick = -1;
        for (int k = 0; k < N; k++) begin
          automatic int idx = (m_ptr + k) % N;
          if (pick < 0 && req_valid[g][idx]) pick = idx;
        end
        if (pick >= 0) begin
          m_owner  <= pick;
          m_ptr    <= (pick + 1) % N;
          m_acc    <= req_access[g][2*pick +: 2];
          m_addr   <= req_addr[g][AW*pick +: AW];
          m_wd     <= req_wdata[g][BW*pick +: BW];
          m_st     <= req_strb[g][SW*pick +: SW];
          m_busy   <= 1;
          m_waited <= 0;
        end
      end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
      chk(g, "o_valid",         q_valid[g],  64'(m_busy));
      chk(g, "o_req_ready",     q_ready[g],  m_pulse ? 64'(N'(1) << m_owner) : 64'(0));
      chk(g, "o_req_status",    q_status[g], 64'(m_stat));
      chk(g, "o_req_read_data", q_rdata[g],  64'(m_rd));
      chk(g, "o_access",        q_access[g], 64'(m_acc));
      chk(g, "o_address",       q_addr[g],   64'(m_addr));
      chk(g, "o_write_data",    q_wdata[g],  64'(m_wd));
      chk(g, "o_strobe",        q_strb[g],   64'(m_st));
    end
  end

  task automatic set_req(input int d, input int r, input logic [1:0] acc, input logic [AW-1:0] addr,
                         input logic [BW-1:0] wd, input logic [SW-1:0] st);
    req_valid[d][r]           = 1'b1;
    req_access[d][2*r +: 2]   = acc;
    req_addr[d][AW*r +: AW]   = addr;
    req_wdata[d][BW*r +: BW]  = wd;
    req_strb[d][SW*r +: SW]   = st;
  endtask

  task automatic clr_req(input int d, input int r);
    req_valid[d][r] = 1'b0;
  endtask

  // reset pulse placed away from both clock edges
  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  logic [N-1:0] seen[4];
  int           n_seen;
  int           n_valid;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0; req_access[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
      req_strb[d] = '0; rdy[d] = 1'b0; rstat[d] = '0; rrd[d] = '0;
    end
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk(0, "reset_valid", q_valid[0], 0);
    chk(1, "reset_ready", q_ready[1], 0);

    // single read, answered on the first BUSY cycle
    do_reset();
    rdy[0] = 1'b1; rstat[0] = 2'b00; rrd[0] = 32'hDEADBEEF;
    set_req(0, 0, 2'b00, 8'h10, 32'h0, 4'h0);
    @(negedge clk);
    chk(0, "t1_valid_c1", q_valid[0], 1);
    chk(0, "t1_addr_c1", q_addr[0], 8'h10);
    @(negedge clk);
    chk(0, "t1_ready_c2", q_ready[0], 2'b01);
    chk(0, "t1_rdata", q_rdata[0], 32'hDEADBEEF);
    chk(0, "t1_status", q_status[0], 2'b00);
    clr_req(0, 0);
    @(negedge clk);
    chk(0, "t1_ready_drop", q_ready[0], 2'b00);

    // round-robin fairness with both requesters always valid
    do_reset();
    rrd[0] = 32'h11110000;
    set_req(0, 0, 2'b00, 8'h30, 32'h0, 4'h0);
    set_req(0, 1, 2'b00, 8'h31, 32'h0, 4'h0);
    n_seen = 0;
    for (int c = 0; c < 40 && n_seen < 4; c++) begin
      @(negedge clk);
      if (q_ready[0] != '0) begin
        seen[n_seen] = q_ready[0];
        n_seen++;
      end
    end
    req_valid[0] = '0;
    chk(0, "rr_pulse_count", n_seen, 4);
    for (int i = 0; i < 4 && i < n_seen; i++)
      chk(0, "rr_grant_order", seen[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    @(negedge clk);

    // payload held while requester 1 scribbles on its inputs
    do_reset();
    rdy[0] = 1'b0; rstat[0] = 2'b01; rrd[0] = 32'h0BADC0DE;
    set_req(0, 1, 2'b01, 8'h24, 32'h12345678, 4'b0011);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk(0, "hold_valid", q_valid[0], 1);
      chk(0, "hold_addr", q_addr[0], 8'h24);
      chk(0, "hold_wdata", q_wdata[0], 32'h12345678);
      chk(0, "hold_strobe", q_strb[0], 4'b0011);
      chk(0, "hold_access", q_access[0], 2'b01);
      set_req(0, 1, 2'b00, 8'h99, $urandom, 4'b1111);
      if (k >= 3) clr_req(0, 1);
      if (k == 6) rdy[0] = 1'b1;
    end
    @(negedge clk);
    chk(0, "hold_ready", q_ready[0], 2'b10);
    chk(0, "hold_rdata", q_rdata[0], 32'h0BADC0DE);
    rdy[0] = 1'b0;

    // watchdog instance: normal access, then an unanswered one
    do_reset();
    rdy[1] = 1'b1; rstat[1] = 2'b01; rrd[1] = 32'hCAFEF00D;
    set_req(1, 0, 2'b00, 8'h40, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    chk(1, "to_pre_ready", q_ready[1], 2'b01);
    chk(1, "to_pre_rdata", q_rdata[1], 32'hCAFEF00D);
    clr_req(1, 0);
    @(negedge clk);
    rdy[1] = 1'b0;
    set_req(1, 0, 2'b00, 8'h44, 32'h0, 4'h0);
    n_valid = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (q_valid[1]) n_valid++;
      if (q_ready[1] != '0) break;
    end
    chk(1, "to_valid_cycles", n_valid, 4);
    chk(1, "to_ready", q_ready[1], 2'b01);
    chk(1, "to_status", q_status[1], 2'b10);
    chk(1, "to_rdata", q_rdata[1], 0);
    clr_req(1, 0);
    @(negedge clk);
    rdy[1] = 1'b1; rstat[1] = 2'b01; rrd[1] = 32'h600D0001;
    set_req(1, 1, 2'b00, 8'h48, 32'h0, 4'h0);
    @(negedge clk);
    chk(1, "to_next_valid", q_valid[1], 1);
    @(negedge clk);
    chk(1, "to_next_ready", q_ready[1], 2'b10);
    chk(1, "to_next_rdata", q_rdata[1], 32'h600D0001);
    clr_req(1, 1);
    @(negedge clk);

    // answer arrives on the very cycle the watchdog would expire
    rdy[1] = 1'b0; rstat[1] = 2'b00; rrd[1] = 32'h5151A5A5;
    set_req(1, 0, 2'b00, 8'h4C, 32'h0, 4'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk(1, "sim_valid", q_valid[1], 1);
      if (k == 4) rdy[1] = 1'b1;
    end
    @(negedge clk);
    chk(1, "sim_ready", q_ready[1], 2'b01);
    chk(1, "sim_status", q_status[1], 2'b00);
    chk(1, "sim_rdata", q_rdata[1], 32'h5151A5A5);
    clr_req(1, 0);
    rdy[1] = 1'b0;

    // reset while BUSY
    do_reset();
    @(negedge clk);
    rdy[0] = 1'b0; rrd[0] = 32'h00000077; rstat[0] = 2'b00;
    set_req(0, 0, 2'b00, 8'h50, 32'hA0A0A0A0, 4'hF);
    repeat (2) @(negedge clk);
    chk(0, "rst_busy_valid", q_valid[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk(0, "rst_valid", q_valid[0], 0);
    chk(0, "rst_addr", q_addr[0], 0);
    chk(0, "rst_wdata", q_wdata[0], 0);
    chk(0, "rst_strobe", q_strb[0], 0);
    chk(0, "rst_ready", q_ready[0], 0);
    chk(0, "rst_rdata", q_rdata[0], 0);
    clr_req(0, 0);
    set_req(0, 1, 2'b00, 8'h54, 32'h0, 4'h0);
    rdy[0] = 1'b1;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk(0, "rst_after_valid", q_valid[0], 1);
    chk(0, "rst_after_addr", q_addr[0], 8'h54);
    @(negedge clk);
    chk(0, "rst_after_ready", q_ready[0], 2'b10);
    clr_req(0, 1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
